// File: rtl/fft_pkg.sv
// Constants, the complex sample type and bit-reversal helper shared by the
// FFT core and its input/output buffers.
package fft_pkg;

    localparam int FFT_N      = 16;
    localparam int FFT_WIDTH  = 16;
    localparam int FFT_ADDR_W = 4;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

    // Reverse the low w bits of idx; bits at and above w are discarded.
    function automatic int unsigned bitrev(input int unsigned idx, input int w);
        int unsigned r;
        r = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < w) begin
                r = r | (((idx >> b) & 32'd1) << (w - 1 - b));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_output_buffer.sv
// Parallel-in, serial-out result buffer for the FFT: captures all bins at once
// and streams them out one per valid/ready transfer, optionally unscrambling
// bit-reversed order.
module fft_output_buffer
    import fft_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int WIDTH  = FFT_WIDTH,
    parameter bit BITREV = 1'b1,
    localparam int ADDR_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic [N*WIDTH-1:0]   yr_flat,
    input  logic [N*WIDTH-1:0]   yi_flat,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [WIDTH-1:0]     yr_out,
    output logic [WIDTH-1:0]     yi_out,
    output logic                 out_last,
    output logic                 drop
);

    // Handshake: a word moves on a rising edge with out_valid & out_ready;
    // while out_ready is low the word and out_valid hold, and out_valid only
    // falls after the final word of a frame has been transferred.

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  cnt;
    logic [WIDTH-1:0]   yr_mem [N];
    logic [WIDTH-1:0]   yi_mem [N];

    logic               xfer;
    logic               at_last;
    logic [ADDR_W-1:0]  rd_idx;

    assign at_last = (cnt == ADDR_W'(N - 1));
    assign xfer    = (state == STREAM) && out_ready;
    assign rd_idx  = BITREV ? ADDR_W'(bitrev(32'(cnt), ADDR_W)) : cnt;

    assign busy      = (state == STREAM);
    assign out_valid = (state == STREAM);
    assign out_last  = (state == STREAM) && at_last;
    assign out_addr  = cnt;
    assign yr_out    = yr_mem[rd_idx];
    assign yi_out    = yi_mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            drop  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                yr_mem[k] <= '0;
                yi_mem[k] <= '0;
            end
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        for (int k = 0; k < N; k++) begin
                            yr_mem[k] <= yr_flat[k*WIDTH +: WIDTH];
                            yi_mem[k] <= yi_flat[k*WIDTH +: WIDTH];
                        end
                        cnt   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    // A capture only lands when it coincides with the final transfer.
                    if (capture && !(xfer && at_last)) begin
                        drop <= 1'b1;
                    end
                    if (xfer) begin
                        if (at_last) begin
                            cnt <= '0;
                            if (capture) begin
                                for (int k = 0; k < N; k++) begin
                                    yr_mem[k] <= yr_flat[k*WIDTH +: WIDTH];
                                    yi_mem[k] <= yi_flat[k*WIDTH +: WIDTH];
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_output_buffer.sv
// Bench for fft_output_buffer: natural-order and bit-reversed instances share
// one stimulus stream; a negedge monitor checks both against expected queues.
module tb_fft_output_buffer;
    import fft_pkg::*;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int AW = 4;
    localparam int EW = AW + 1 + 2*W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           capture = 1'b0;
    logic [N*W-1:0] yr_flat = '0;
    logic [N*W-1:0] yi_flat = '0;
    logic           out_ready = 1'b1;

    logic           busy0, out_valid0, out_last0, drop0;
    logic [AW-1:0]  out_addr0;
    logic [W-1:0]   yr_out0, yi_out0;
    logic           busy1, out_valid1, out_last1, drop1;
    logic [AW-1:0]  out_addr1;
    logic [W-1:0]   yr_out1, yi_out1;

    fft_output_buffer #(.N(N), .WIDTH(W), .BITREV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .capture(capture), .yr_flat(yr_flat), .yi_flat(yi_flat),
        .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready), .out_addr(out_addr0),
        .yr_out(yr_out0), .yi_out(yi_out0), .out_last(out_last0), .drop(drop0)
    );

    fft_output_buffer #(.N(N), .WIDTH(W), .BITREV(1'b1)) dut1 (
        .clk(clk), .rst(rst), .capture(capture), .yr_flat(yr_flat), .yi_flat(yi_flat),
        .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready), .out_addr(out_addr1),
        .yr_out(yr_out1), .yi_out(yi_out1), .out_last(out_last1), .drop(drop1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int checks = 0;
    int failures = 0;
    int exp_drops = 0;
    int drops_seen0 = 0;
    int drops_seen1 = 0;
    logic [W-1:0] fr_re [N];
    logic [W-1:0] fr_im [N];
    cplx_t last_seen1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int rev4(input int i);
        logic [3:0] b;
        b = i[3:0];
        return {28'd0, b[0], b[1], b[2], b[3]};
    endfunction

    // ---------------- monitor ----------------
    task automatic mon_word(input int p, input logic [EW-1:0] act, input logic rdy);
        logic [EW-1:0] exp;
        checks++;
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            failures++;
            $display("FAIL unexpected_word dut%0d actual=%0h expected=none", p, act);
        end else begin
            exp = (p == 0) ? exp_q0[0] : exp_q1[0];
            if (act !== exp) begin
                failures++;
                $display("FAIL word dut%0d actual addr=%0d last=%0b re=%0h im=%0h expected addr=%0d last=%0b re=%0h im=%0h",
                         p, act[EW-1 -: AW], act[2*W], act[2*W-1 -: W], act[W-1:0],
                         exp[EW-1 -: AW], exp[2*W], exp[2*W-1 -: W], exp[W-1:0]);
            end
            if (rdy) begin
                if (p == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid0) mon_word(0, {out_addr0, out_last0, yr_out0, yi_out0}, out_ready);
            if (out_valid1) begin
                mon_word(1, {out_addr1, out_last1, yr_out1, yi_out1}, out_ready);
                last_seen1 = {yr_out1, yi_out1};
            end
            if (drop0) drops_seen0++;
            if (drop1) drops_seen1++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_frame(input int f);
        for (int k = 0; k < N; k++) begin
            case (f)
                0:       begin fr_re[k] = 16'(k * 256);        fr_im[k] = 16'(-k);          end
                1:       begin fr_re[k] = 16'(100 + k);        fr_im[k] = 16'(3 * k);       end
                default: begin fr_re[k] = 16'(-(16 * k) - 1);  fr_im[k] = 16'((k << 8) + 7); end
            endcase
            yr_flat[k*W +: W] = fr_re[k];
            yi_flat[k*W +: W] = fi_sel(k);
        end
    endtask

    function automatic logic [W-1:0] fi_sel(input int k);
        return fr_im[k];
    endfunction

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            exp_q0.push_back({4'(i), (i == N-1), fr_re[i], fr_im[i]});
            exp_q1.push_back({4'(i), (i == N-1), fr_re[rev4(i)], fr_im[rev4(i)]});
        end
    endtask

    task automatic capture_frame(input int f, input bit accepted);
        load_frame(f);
        if (accepted) push_frame();
        capture = 1'b1;
        @(posedge clk);
        #1 capture = 1'b0;
    endtask

    task automatic drain(input string name, input bit bp, input int budget);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            if (bp) out_ready = (n % 4 == 0) || (n % 4 == 3);
            n++;
        end
        out_ready = 1'b1;
        check({name, "_drain_timeout"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        // Reset state
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_busy",      {31'd0, busy1}, 32'd0);
        check("rst_out_last",  {31'd0, out_last0}, 32'd0);
        check("rst_out_addr",  32'(out_addr1), 32'd0);
        check("rst_yr_out",    32'(yr_out0), 32'd0);
        check("rst_yi_out",    32'(yi_out1), 32'd0);
        check("rst_drop",      {31'd0, drop0}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Frame A in natural and bit-reversed order, one-cycle latency
        capture_frame(0, 1'b1);
        check("lat_out_valid", {31'd0, out_valid0}, 32'd1);
        check("lat_out_addr",  32'(out_addr0), 32'd0);
        check("lat_busy",      {31'd0, busy1}, 32'd1);
        drain("frameA", 1'b0, 100);
        @(posedge clk);
        #1;
        check("busy_fall0", {31'd0, busy0}, 32'd0);
        check("busy_fall1", {31'd0, busy1}, 32'd0);
        check("bitrev_last_word", 32'(last_seen1), {16'd3840, 16'hfff1});

        // Backpressure with out_ready pattern 1,0,0,1
        capture_frame(1, 1'b1);
        drain("backpressure", 1'b1, 200);
        repeat (2) @(posedge clk);
        #1;

        // Collision at word 5, then back-to-back capture at word 15
        capture_frame(0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("coll_at_word5", 32'(out_addr0), 32'd5);
        capture_frame(1, 1'b0);
        exp_drops++;
        check("drop_pulse", {31'd0, drop0}, 32'd1);
        @(posedge clk);
        #1;
        check("drop_clear", {31'd0, drop0}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("b2b_at_word15", {31'd0, out_last0}, 32'd1);
        capture_frame(2, 1'b1);
        check("b2b_no_gap_valid", {31'd0, out_valid0}, 32'd1);
        check("b2b_no_gap_addr",  32'(out_addr1), 32'd0);
        check("b2b_no_drop",      {31'd0, drop1}, 32'd0);
        drain("backtoback", 1'b0, 100);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        capture_frame(0, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        check("mid_at_word7", 32'(out_addr0), 32'd7);
        #2;
        rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check("mid_rst_valid", {31'd0, out_valid0}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy1}, 32'd0);
        check("mid_rst_yr",    32'(yr_out1), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, out_valid0 | out_valid1}, 32'd0);

        // Normal operation resumes after reset
        capture_frame(2, 1'b1);
        drain("after_reset", 1'b0, 100);
        repeat (2) @(posedge clk);
        #1;

        check("drops_seen0", 32'(drops_seen0), 32'(exp_drops));
        check("drops_seen1", 32'(drops_seen1), 32'(exp_drops));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
